// File: rtl/ras_stack_pkg.sv
// Shared fetch-stage definitions for the return address stack: BTB RAS
// control encodings and the checkpoint record carried with each branch.
package ras_stack_pkg;

    localparam int RAS_DEPTH = 16;
    localparam int RAS_PTR_W = $clog2(RAS_DEPTH);
    localparam int RAS_AW    = 64;

    typedef enum logic [1:0] {
        RAS_CTL_NONE    = 2'b00,
        RAS_CTL_PUSH    = 2'b01,
        RAS_CTL_POP     = 2'b10,
        RAS_CTL_POPPUSH = 2'b11
    } ras_ctl_e;

    // Snapshot of the stack taken alongside every prediction; the branch tag
    // carries it so a mispredict redirect can restore the speculative stack.
    typedef struct packed {
        logic [RAS_PTR_W-1:0] tos;
        logic [RAS_PTR_W:0]   cnt;
        logic [RAS_AW-1:0]    top;
    } ras_ckpt_t;

endpackage

// File: rtl/ras_stack.sv
// Speculative return address stack. Circular storage indexed by a top-of-stack
// pointer; occupancy saturates at DEPTH so overflow silently overwrites the
// oldest entry. Reads are combinational so fetch can redirect in-cycle.
module ras_stack
    import ras_stack_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int AW    = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ras_vld_i,
    input  logic [1:0]       ras_ctl_i,
    input  logic [AW-1:0]    ras_push_addr_i,
    input  logic             ras_rcv_i,
    input  logic [PTR_W-1:0] ras_rcv_tos_i,
    input  logic [PTR_W:0]   ras_rcv_cnt_i,
    input  logic [AW-1:0]    ras_rcv_top_i,
    output logic [AW-1:0]    ras_tar_o,
    output logic             ras_empty_o,
    output logic [PTR_W-1:0] ras_ckpt_tos_o,
    output logic [PTR_W:0]   ras_ckpt_cnt_o,
    output logic [AW-1:0]    ras_ckpt_top_o
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [AW-1:0]    mem_q [DEPTH];
    logic [PTR_W-1:0] tos_q, tos_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic             wr_en;
    logic [PTR_W-1:0] wr_addr;
    logic [AW-1:0]    wr_data;
    logic [AW-1:0]    top_val;
    ras_ctl_e         ctl;

    assign ctl = ras_ctl_e'(ras_ctl_i);

    // Read side: present the top entry, masked to zero when the stack is empty.
    always_comb begin
        top_val        = (cnt_q == '0) ? '0 : mem_q[tos_q];
        ras_tar_o      = top_val;
        ras_ckpt_top_o = top_val;
        ras_ckpt_tos_o = tos_q;
        ras_ckpt_cnt_o = cnt_q;
        ras_empty_o    = (cnt_q == '0);
    end

    // Next-state pointer/occupancy and the single memory write port.
    // Recover wins over any same-cycle operation since that fetch is squashed.
    always_comb begin
        tos_d   = tos_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        wr_addr = tos_q;
        wr_data = ras_push_addr_i;
        if (ras_rcv_i) begin
            tos_d   = ras_rcv_tos_i;
            cnt_d   = (ras_rcv_cnt_i > FULL_CNT) ? FULL_CNT : ras_rcv_cnt_i;
            wr_en   = 1'b1;
            wr_addr = ras_rcv_tos_i;
            wr_data = ras_rcv_top_i;
        end else if (ras_vld_i) begin
            case (ctl)
                RAS_CTL_PUSH: begin
                    tos_d   = tos_q + 1'b1;
                    cnt_d   = (cnt_q == FULL_CNT) ? cnt_q : cnt_q + 1'b1;
                    wr_en   = 1'b1;
                    wr_addr = tos_q + 1'b1;
                end
                RAS_CTL_POP: begin
                    if (cnt_q != '0) begin
                        tos_d = tos_q - 1'b1;
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                RAS_CTL_POPPUSH: begin
                    // Coroutine swap replaces the top in place; on an empty
                    // stack there is nothing to pop, so it degrades to a push.
                    wr_en = 1'b1;
                    if (cnt_q == '0) begin
                        tos_d   = tos_q + 1'b1;
                        cnt_d   = cnt_q + 1'b1;
                        wr_addr = tos_q + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            tos_q <= '0;
            cnt_q <= '0;
        end else begin
            tos_q <= tos_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry storage is deliberately not reset; a write is suppressed under reset.
    always_ff @(posedge clock) begin
        if (wr_en && !reset) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_ras_stack.sv
module tb_ras_stack;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;
    localparam int AW    = 32;

    logic             clock = 1'b0;
    logic             reset;
    logic             ras_vld_i;
    logic [1:0]       ras_ctl_i;
    logic [AW-1:0]    ras_push_addr_i;
    logic             ras_rcv_i;
    logic [PTR_W-1:0] ras_rcv_tos_i;
    logic [PTR_W:0]   ras_rcv_cnt_i;
    logic [AW-1:0]    ras_rcv_top_i;
    logic [AW-1:0]    ras_tar_o;
    logic             ras_empty_o;
    logic [PTR_W-1:0] ras_ckpt_tos_o;
    logic [PTR_W:0]   ras_ckpt_cnt_o;
    logic [AW-1:0]    ras_ckpt_top_o;

    ras_stack #(.DEPTH(DEPTH), .PTR_W(PTR_W), .AW(AW)) dut (
        .clock(clock),
        .reset(reset),
        .ras_vld_i(ras_vld_i),
        .ras_ctl_i(ras_ctl_i),
        .ras_push_addr_i(ras_push_addr_i),
        .ras_rcv_i(ras_rcv_i),
        .ras_rcv_tos_i(ras_rcv_tos_i),
        .ras_rcv_cnt_i(ras_rcv_cnt_i),
        .ras_rcv_top_i(ras_rcv_top_i),
        .ras_tar_o(ras_tar_o),
        .ras_empty_o(ras_empty_o),
        .ras_ckpt_tos_o(ras_ckpt_tos_o),
        .ras_ckpt_cnt_o(ras_ckpt_cnt_o),
        .ras_ckpt_top_o(ras_ckpt_top_o)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          rst;
        bit          vld;
        logic [1:0]  ctl;
        logic [31:0] addr;
        bit          rcv;
        int          rtos;
        int          rcnt;
        logic [31:0] rtop;
        bit          e_empty;
        logic [31:0] e_tar;
        int          e_tos;
        int          e_cnt;
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: stack as an array of slots with modular pointer math.
    int          m_tos, m_cnt;
    logic [31:0] m_mem [DEPTH];
    bit          m_known [DEPTH];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input bit rst, input bit vld, input logic [1:0] ctl, input logic [31:0] addr,
                       input bit rcv, input int rtos, input int rcnt, input logic [31:0] rtop,
                       input bit e_empty, input logic [31:0] e_tar, input int e_tos, input int e_cnt);
        vec_t v;
        v.rst = rst; v.vld = vld; v.ctl = ctl; v.addr = addr;
        v.rcv = rcv; v.rtos = rtos; v.rcnt = rcnt; v.rtop = rtop;
        v.e_empty = e_empty; v.e_tar = e_tar; v.e_tos = e_tos; v.e_cnt = e_cnt;
        vecs.push_back(v);
    endtask

    task automatic drive(input bit rst, input bit vld, input logic [1:0] ctl, input logic [31:0] addr,
                         input bit rcv, input int rtos, input int rcnt, input logic [31:0] rtop);
        reset           = rst;
        ras_vld_i       = vld;
        ras_ctl_i       = ctl;
        ras_push_addr_i = addr;
        ras_rcv_i       = rcv;
        ras_rcv_tos_i   = PTR_W'(rtos);
        ras_rcv_cnt_i   = (PTR_W+1)'(rcnt);
        ras_rcv_top_i   = rtop;
    endtask

    task automatic model_push(input logic [31:0] a);
        m_tos = (m_tos + 1) % DEPTH;
        m_mem[m_tos] = a;
        m_known[m_tos] = 1'b1;
        m_cnt = (m_cnt + 1 > DEPTH) ? DEPTH : m_cnt + 1;
    endtask

    task automatic model_step(input bit rst, input bit vld, input logic [1:0] ctl, input logic [31:0] addr,
                              input bit rcv, input int rtos, input int rcnt, input logic [31:0] rtop);
        if (rst) begin
            m_tos = 0;
            m_cnt = 0;
        end else if (rcv) begin
            m_tos = rtos;
            m_cnt = (rcnt > DEPTH) ? DEPTH : rcnt;
            m_mem[rtos] = rtop;
            m_known[rtos] = 1'b1;
        end else if (vld) begin
            if (ctl == 2'b01) model_push(addr);
            else if (ctl == 2'b10) begin
                if (m_cnt > 0) begin
                    m_tos = (m_tos + DEPTH - 1) % DEPTH;
                    m_cnt = m_cnt - 1;
                end
            end else if (ctl == 2'b11) begin
                if (m_cnt > 0) m_mem[m_tos] = addr;
                else model_push(addr);
            end
        end
    endtask

    initial begin
        drive(1, 0, 2'b00, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clock);
        #1;
        chk("reset_empty", ras_empty_o, 1);
        chk("reset_tar", ras_tar_o, 0);
        chk("reset_tos", ras_ckpt_tos_o, 0);
        chk("reset_cnt", ras_ckpt_cnt_o, 0);
        chk("reset_top", ras_ckpt_top_o, 0);

        //  rst vld ctl   addr      rcv tos cnt top       empty tar       tos cnt
        add(0, 1, 2'b01, 32'h1000, 0, 0, 0, 0,          0, 32'h1000, 1, 1);
        add(0, 1, 2'b01, 32'h2000, 0, 0, 0, 0,          0, 32'h2000, 2, 2);
        add(0, 1, 2'b10, 0,        0, 0, 0, 0,          0, 32'h1000, 1, 1);
        add(0, 1, 2'b10, 0,        0, 0, 0, 0,          1, 0,        0, 0);
        add(0, 1, 2'b10, 0,        0, 0, 0, 0,          1, 0,        0, 0);
        add(0, 1, 2'b01, 32'hA0,   0, 0, 0, 0,          0, 32'hA0,   1, 1);
        add(0, 1, 2'b01, 32'hA4,   0, 0, 0, 0,          0, 32'hA4,   2, 2);
        add(0, 1, 2'b01, 32'hA8,   0, 0, 0, 0,          0, 32'hA8,   3, 3);
        add(0, 1, 2'b01, 32'hAC,   0, 0, 0, 0,          0, 32'hAC,   0, 4);
        add(0, 1, 2'b01, 32'hB0,   0, 0, 0, 0,          0, 32'hB0,   1, 4);
        add(0, 1, 2'b10, 0,        0, 0, 0, 0,          0, 32'hAC,   0, 3);
        add(0, 1, 2'b10, 0,        0, 0, 0, 0,          0, 32'hA8,   3, 2);
        add(0, 1, 2'b10, 0,        0, 0, 0, 0,          0, 32'hA4,   2, 1);
        add(0, 1, 2'b10, 0,        0, 0, 0, 0,          1, 0,        1, 0);
        add(1, 0, 2'b00, 0,        0, 0, 0, 0,          1, 0,        0, 0);
        add(0, 1, 2'b01, 32'h100,  0, 0, 0, 0,          0, 32'h100,  1, 1);
        add(0, 1, 2'b01, 32'h200,  0, 0, 0, 0,          0, 32'h200,  2, 2);
        add(0, 1, 2'b11, 32'h300,  0, 0, 0, 0,          0, 32'h300,  2, 2);
        add(0, 1, 2'b10, 0,        0, 0, 0, 0,          0, 32'h100,  1, 1);
        add(0, 1, 2'b01, 32'h500,  0, 0, 0, 0,          0, 32'h500,  2, 2);
        add(0, 1, 2'b11, 32'h600,  0, 0, 0, 0,          0, 32'h600,  2, 2);
        add(0, 1, 2'b01, 32'h700,  1, 1, 1, 32'h100,    0, 32'h100,  1, 1);
        add(0, 1, 2'b10, 0,        0, 0, 0, 0,          1, 0,        0, 0);
        add(0, 1, 2'b01, 32'h900,  0, 0, 0, 0,          0, 32'h900,  1, 1);
        add(1, 1, 2'b01, 32'h800,  1, 3, 3, 32'h123,    1, 0,        0, 0);
        add(0, 0, 2'b01, 32'hBAD,  1, 3, 7, 32'hDEAD,   0, 32'hDEAD, 3, 4);
        add(0, 0, 2'b01, 32'hBAD,  0, 0, 0, 0,          0, 32'hDEAD, 3, 4);
        add(0, 1, 2'b00, 32'hBAD,  0, 0, 0, 0,          0, 32'hDEAD, 3, 4);
        add(1, 0, 2'b00, 0,        0, 0, 0, 0,          1, 0,        0, 0);
        add(0, 1, 2'b11, 32'h44,   0, 0, 0, 0,          0, 32'h44,   1, 1);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].vld, vecs[i].ctl, vecs[i].addr,
                  vecs[i].rcv, vecs[i].rtos, vecs[i].rcnt, vecs[i].rtop);
            @(posedge clock);
            #1;
            chk($sformatf("v%0d_empty", i), ras_empty_o, vecs[i].e_empty);
            chk($sformatf("v%0d_tar", i), ras_tar_o, vecs[i].e_tar);
            chk($sformatf("v%0d_top", i), ras_ckpt_top_o, vecs[i].e_tar);
            chk($sformatf("v%0d_tos", i), ras_ckpt_tos_o, vecs[i].e_tos);
            chk($sformatf("v%0d_cnt", i), ras_ckpt_cnt_o, vecs[i].e_cnt);
        end

        // Pop-push must expose the old top in the operation cycle itself.
        drive(0, 1, 2'b01, 32'h77, 0, 0, 0, 0);
        @(posedge clock); #1;
        drive(0, 1, 2'b11, 32'h88, 0, 0, 0, 0);
        #2;
        chk("poppush_same_cycle", ras_tar_o, 32'h77);
        @(posedge clock); #1;
        chk("poppush_next", ras_tar_o, 32'h88);
        chk("poppush_cnt", ras_ckpt_cnt_o, 2);

        // Randomized phase against the reference model.
        drive(1, 0, 2'b00, 0, 0, 0, 0, 0);
        @(posedge clock); #1;
        m_tos = 0;
        m_cnt = 0;
        for (int k = 0; k < DEPTH; k++) m_known[k] = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            bit          r_rst, r_vld, r_rcv;
            logic [1:0]  r_ctl;
            logic [31:0] r_addr, r_top;
            int          r_tos, r_cnt;
            r_rst  = ($urandom_range(63) == 0);
            r_vld  = ($urandom_range(3) != 0);
            r_ctl  = 2'($urandom_range(3));
            r_addr = $urandom;
            r_rcv  = ($urandom_range(9) == 0);
            r_tos  = $urandom_range(DEPTH - 1);
            r_cnt  = $urandom_range(7);
            r_top  = $urandom;
            drive(r_rst, r_vld, r_ctl, r_addr, r_rcv, r_tos, r_cnt, r_top);
            @(posedge clock);
            model_step(r_rst, r_vld, r_ctl, r_addr, r_rcv, r_tos, r_cnt, r_top);
            #1;
            chk("rnd_empty", ras_empty_o, (m_cnt == 0));
            chk("rnd_tos", ras_ckpt_tos_o, m_tos);
            chk("rnd_cnt", ras_ckpt_cnt_o, m_cnt);
            if (m_cnt == 0) begin
                chk("rnd_tar", ras_tar_o, 0);
                chk("rnd_top", ras_ckpt_top_o, 0);
            end else if (m_known[m_tos]) begin
                chk("rnd_tar", ras_tar_o, m_mem[m_tos]);
                chk("rnd_top", ras_ckpt_top_o, m_mem[m_tos]);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ras_stack.md
Name: ras_stack

Overview:
- Speculative return address stack in fetch stage 1, directly downstream of the branch target buffer (BTB).
- Consumes the BTB's RAS-control code on a BTB hit:
  - Call: pushes the return address.
  - Return: supplies the predicted target and pops.
  - Coroutine (JSR_COROUTINE): swaps the top entry.
- Exports a per-prediction checkpoint. Restores from a checkpoint on a backend mispredict redirect.

Parameters:
- DEPTH, 16, number of stack entries; power of two, minimum 2.
- PTR_W, $clog2(DEPTH), top-of-stack (TOS) pointer width.
- AW, 64, address width.

Ports:
- clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- ras_vld_i  in  1  qualifies ras_ctl_i (BTB hit and fetch bundle valid, not stalled).
- ras_ctl_i  in  2  BTB RAS control: 00 none, 01 push, 10 pop, 11 pop-push.
- ras_push_addr_i  in  AW  return address to push (branch PC + 4).
- ras_rcv_i  in  1  recover strobe from the retire/redirect path.
- ras_rcv_tos_i  in  PTR_W  checkpointed TOS pointer.
- ras_rcv_cnt_i  in  PTR_W+1  checkpointed occupancy.
- ras_rcv_top_i  in  AW  checkpointed top-entry value.
- ras_tar_o  out  AW  predicted return target (current top entry).
- ras_empty_o  out  1  stack holds no entries.
- ras_ckpt_tos_o  out  PTR_W  current TOS, to be carried with the branch.
- ras_ckpt_cnt_o  out  PTR_W+1  current occupancy.
- ras_ckpt_top_o  out  AW  current top-entry value.

Behaviour:
- State:
  - mem[DEPTH] of AW bits; memory is not reset.
  - tos (PTR_W bits), pointing at the current top entry.
  - cnt (PTR_W+1 bits), saturating at DEPTH.
- Reset (synchronous, while reset=1):
  - tos=0, cnt=0.
  - Outputs: ras_empty_o=1, ras_tar_o=0, ras_ckpt_tos_o=0, ras_ckpt_cnt_o=0, ras_ckpt_top_o=0.
  - Reset overrides recover and any operation in the same cycle.
- Outputs are combinational from current (pre-update) state, with zero-cycle read latency so fetch redirects in the same cycle:
  - ras_tar_o and ras_ckpt_top_o = (cnt==0) ? 0 : mem[tos].
  - ras_ckpt_tos_o = tos.
  - ras_ckpt_cnt_o = cnt.
  - ras_empty_o = (cnt==0).
- Updates take effect on the next edge. Operations occur only when ras_vld_i=1 and ras_rcv_i=0.
- Push (01):
  - tos <= tos+1 (mod DEPTH); mem[tos+1] <= ras_push_addr_i.
  - cnt <= min(cnt+1, DEPTH).
  - When full, the push wraps and overwrites the oldest entry; cnt stays at DEPTH.
- Pop (10):
  - If cnt>0: tos <= tos-1 (mod DEPTH), cnt <= cnt-1.
  - If cnt==0: no state change. ras_tar_o is 0 and fetch ignores it via ras_empty_o.
- Pop-push (11):
  - If cnt>0: mem[tos] <= ras_push_addr_i; tos and cnt unchanged. ras_tar_o gives the old top in the same cycle.
  - If cnt==0: behaves as push.
- None (00) or ras_vld_i=0: no change.
- Recover (ras_rcv_i=1):
  - tos <= ras_rcv_tos_i, cnt <= ras_rcv_cnt_i, mem[ras_rcv_tos_i] <= ras_rcv_top_i.
  - Recover has priority: any same-cycle push/pop is dropped, because that fetch is squashed.
  - A ras_rcv_cnt_i value above DEPTH is clamped to DEPTH.
- Pointer arithmetic is modulo DEPTH; no underflow or overflow flags.
- Entries overwritten by wrap are lost. After wrap, deep pops return newer data. This is accepted predictor inaccuracy, not an error.

Decomposition:
- Shared fetch package holds:
  - RAS_CTL_NONE=2'b00, RAS_CTL_PUSH=2'b01, RAS_CTL_POP=2'b10, RAS_CTL_POPPUSH=2'b11.
  - A ras_ckpt_t struct {tos, cnt, top}, also used by the branch tag carried down the pipeline.
- No sub-module: storage array, pointer and counter logic all live in ras_stack.

Test Plan (DEPTH=4):
- Reset, then push 0x1000 and 0x2000 → ras_tar_o=0x2000, cnt=2, tos=2. Pop → next cycle ras_tar_o=0x1000, cnt=1.
- Pop with cnt==0 → tos/cnt unchanged, ras_empty_o=1, ras_tar_o=0.
- Push 0xA0, 0xA4, 0xA8, 0xAC, 0xB0 (overflow) → cnt=4, ras_tar_o=0xB0. Four pops yield 0xB0, 0xAC, 0xA8, 0xA4, then empty.
- Stack [0x100, 0x200], pop-push 0x300 → ras_tar_o=0x200 in the op cycle. Next cycle ras_tar_o=0x300, cnt=2.
- Capture checkpoint {tos=1, cnt=1, top=0x100}; push 0x500, then pop-push 0x600; assert ras_rcv_i with that checkpoint alongside a same-cycle push of 0x700 → push dropped, next cycle ras_tar_o=0x100, cnt=1, tos=1.
- Assert reset together with ras_rcv_i and a push → next cycle cnt=0, tos=0, ras_empty_o=1.
